// File: rtl/toggle_cdc_pkg.sv
// rtl/toggle_cdc_pkg.sv - shared types and constants for the toggle-handshake CDC channel
package toggle_cdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - N-stage single-bit synchronizer with synchronous active-low reset
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync;

    // Plain shift chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[N-2:0], d};
        end
    end

    assign q = sync[N-1];

endmodule

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - read-domain end of a toggle-handshake bundled-data crossing
module toggle_hs_rx
    import toggle_cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              rd_clk,
    input  logic              rd_reset,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tog,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              err_overrun,
    output logic [CNT_W-1:0]  xfer_cnt
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("toggle_hs_rx: SYNC_STAGES must be at least MIN_SYNC_STAGES");
    end

    logic   req_s;
    logic   pending;
    state_t state;

    bit_sync #(
        .N(SYNC_STAGES)
    ) u_req_sync (
        .clk     (rd_clk),
        .reset_n (rd_reset),
        .d       (req_tog),
        .q       (req_s)
    );

    assign pending = req_s ^ ack_tog;

    always_ff @(posedge rd_clk) begin
        if (!rd_reset) begin
            state       <= IDLE;
            ack_tog     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            err_overrun <= 1'b0;
            xfer_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_data is bundled: stable whenever pending is seen, so no sync needed.
                    if (pending) begin
                        rd_data  <= req_data;
                        rd_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // Sender toggled again before our ack: flag it, keep the current word.
                    if (req_s == ack_tog) begin
                        err_overrun <= 1'b1;
                    end
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        ack_tog  <= ~ack_tog;
                        xfer_cnt <= xfer_cnt + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb/tb_toggle_hs_rx.sv - directed self-checking bench for toggle_hs_rx
module tb_toggle_hs_rx;

    logic        rd_clk = 1'b0;
    logic        rd_reset;
    logic        req_tog;
    logic [7:0]  req_data;
    logic        rd_ready;

    logic        ack_tog;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        err_overrun;
    logic [15:0] xfer_cnt;

    logic        ack_tog4;
    logic [7:0]  rd_data4;
    logic        rd_valid4;
    logic        err_overrun4;
    logic [3:0]  xfer_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 rd_clk = ~rd_clk;

    toggle_hs_rx dut (
        .rd_clk      (rd_clk),
        .rd_reset    (rd_reset),
        .req_tog     (req_tog),
        .req_data    (req_data),
        .ack_tog     (ack_tog),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .err_overrun (err_overrun),
        .xfer_cnt    (xfer_cnt)
    );

    toggle_hs_rx #(
        .CNT_W(4)
    ) dut_w4 (
        .rd_clk      (rd_clk),
        .rd_reset    (rd_reset),
        .req_tog     (req_tog),
        .req_data    (req_data),
        .ack_tog     (ack_tog4),
        .rd_data     (rd_data4),
        .rd_valid    (rd_valid4),
        .rd_ready    (rd_ready),
        .err_overrun (err_overrun4),
        .xfer_cnt    (xfer_cnt4)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_ack;

        rd_reset = 1'b0;
        req_tog  = 1'b0;
        req_data = 8'h00;
        rd_ready = 1'b0;
        step(3);
        rd_reset = 1'b1;
        step(10);
        chk("reset_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_ack", {31'd0, ack_tog}, 32'd0);
        chk("reset_cnt", {16'd0, xfer_cnt}, 32'd0);
        chk("reset_err", {31'd0, err_overrun}, 32'd0);
        chk("reset_data", {24'd0, rd_data}, 32'd0);

        // Basic latency: toggle before edge E, valid after E+2, ack after E+3.
        req_data = 8'hA5;
        req_tog  = 1'b1;
        rd_ready = 1'b1;
        step(2);
        chk("lat_valid_e1", {31'd0, rd_valid}, 32'd0);
        step(1);
        chk("lat_valid_e2", {31'd0, rd_valid}, 32'd1);
        chk("lat_data_e2", {24'd0, rd_data}, 32'hA5);
        chk("lat_ack_e2", {31'd0, ack_tog}, 32'd0);
        step(1);
        chk("lat_ack_e3", {31'd0, ack_tog}, 32'd1);
        chk("lat_cnt_e3", {16'd0, xfer_cnt}, 32'd1);
        chk("lat_valid_e3", {31'd0, rd_valid}, 32'd0);

        // Backpressure: word and ack held while rd_ready is low.
        rd_ready = 1'b0;
        req_data = 8'h3C;
        req_tog  = 1'b0;
        step(3);
        chk("bp_valid", {31'd0, rd_valid}, 32'd1);
        step(5);
        chk("bp_valid_held", {31'd0, rd_valid}, 32'd1);
        chk("bp_data_held", {24'd0, rd_data}, 32'h3C);
        chk("bp_ack_held", {31'd0, ack_tog}, 32'd1);
        chk("bp_cnt_held", {16'd0, xfer_cnt}, 32'd1);
        rd_ready = 1'b1;
        step(1);
        chk("bp_accept_valid", {31'd0, rd_valid}, 32'd0);
        chk("bp_accept_ack", {31'd0, ack_tog}, 32'd0);
        chk("bp_accept_cnt", {16'd0, xfer_cnt}, 32'd2);

        // Clean restart, then four in-order transfers.
        rd_reset = 1'b0;
        step(1);
        rd_reset = 1'b1;
        chk("rst2_cnt", {16'd0, xfer_cnt}, 32'd0);
        exp_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            req_data = 8'(k);
            req_tog  = ~req_tog;
            step(3);
            chk("seq_valid", {31'd0, rd_valid}, 32'd1);
            chk("seq_data", {24'd0, rd_data}, k);
            step(1);
            exp_ack = ~exp_ack;
            chk("seq_ack", {31'd0, ack_tog}, {31'd0, exp_ack});
        end
        chk("seq_cnt", {16'd0, xfer_cnt}, 32'd4);

        // Overrun: second toggle while the first word is still held.
        rd_ready = 1'b0;
        req_data = 8'h5A;
        req_tog  = 1'b1;
        step(3);
        chk("ovr_valid", {31'd0, rd_valid}, 32'd1);
        req_tog = 1'b0;
        step(2);
        chk("ovr_err_early", {31'd0, err_overrun}, 32'd0);
        step(1);
        chk("ovr_err_set", {31'd0, err_overrun}, 32'd1);
        chk("ovr_data_kept", {24'd0, rd_data}, 32'h5A);
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
        chk("ovr_accept_ack", {31'd0, ack_tog}, 32'd1);
        chk("ovr_accept_cnt", {16'd0, xfer_cnt}, 32'd5);
        chk("ovr_err_sticky", {31'd0, err_overrun}, 32'd1);
        step(1);
        chk("ovr_second_valid", {31'd0, rd_valid}, 32'd1);
        chk("ovr_err_still", {31'd0, err_overrun}, 32'd1);

        // One-cycle reset while in HOLD drops the word and clears everything.
        rd_reset = 1'b0;
        step(1);
        rd_reset = 1'b1;
        chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
        chk("midrst_ack", {31'd0, ack_tog}, 32'd0);
        chk("midrst_cnt", {16'd0, xfer_cnt}, 32'd0);
        chk("midrst_err", {31'd0, err_overrun}, 32'd0);
        rd_ready = 1'b1;
        step(4);
        chk("idle_ready_ignored_valid", {31'd0, rd_valid}, 32'd0);
        chk("idle_ready_ignored_cnt", {16'd0, xfer_cnt}, 32'd0);

        // 17 transfers: 16-bit counter reads 17, 4-bit counter wraps to 1.
        for (int k = 0; k < 17; k++) begin
            req_data = 8'(8'h80 + k);
            req_tog  = ~req_tog;
            step(4);
        end
        chk("wrap_cnt16", {16'd0, xfer_cnt}, 32'd17);
        chk("wrap_cnt4", {28'd0, xfer_cnt4}, 32'd1);
        chk("wrap_ack", {31'd0, ack_tog}, 32'd1);
        chk("wrap_last_data", {24'd0, rd_data}, 32'h90);
        chk("wrap_err", {31'd0, err_overrun4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
